// File: rtl/serial_tx.sv
// Byte-wide UART-style serial transmitter: start bit, 8 data bits LSB first,
// optional parity bit, one or two stop bits; each bit lasts CLKS_PER_BIT cycles.
module serial_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  output logic       tx_done_o,
  output logic       txd_o
);

  localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic              PAR_EN    = (PARITY_EN != 0);
  localparam logic              PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        data_q, data_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = bit_end ? '0 : baud_q + 1'b1;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    txd_d     = txd_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d    = '0;
        bit_idx_d = '0;
        txd_d     = 1'b1;
        ready_d   = 1'b1;
        if (ready_q && tx_start_i) begin
          data_d  = tx_data_i;
          state_d = START;
          txd_d   = 1'b0;
          ready_d = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = '0;
          txd_d     = data_q[0];
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            if (PAR_EN) begin
              state_d = PARITY;
              txd_d   = (^data_q) ^ PAR_ODD;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = data_q[bit_idx_q + 3'd1];
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          bit_idx_d = '0;
          txd_d     = 1'b1;
        end
      end

      STOP: begin
        // The bit index doubles as the stop-bit counter.
        if (bit_end) begin
          if (bit_idx_q == STOP_LAST) begin
            state_d   = IDLE;
            bit_idx_d = '0;
            ready_d   = 1'b1;
            done_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        baud_d    = '0;
        bit_idx_d = '0;
        txd_d     = 1'b1;
        ready_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  assign txd_o      = txd_q;
  assign tx_ready_o = ready_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Drives four serial_tx configurations (8N1, 8E1, 8O1, 8N2; 4 clocks per bit) with
// shared stimulus and checks them every cycle against a frame-level timing model.
module tb_serial_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire  [3:0] act_ready;
  wire  [3:0] act_done;
  wire  [3:0] act_txd;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_tx #(
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   ((g == 1 || g == 2) ? 1 : 0),
      .PARITY_ODD  ((g == 2) ? 1 : 0),
      .STOP_BITS   ((g == 3) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .tx_start_i(tx_start),
      .tx_data_i (tx_data),
      .tx_ready_o(act_ready[g]),
      .tx_done_o (act_done[g]),
      .txd_o     (act_txd[g])
    );
  end

  function automatic int parEn(input int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int stopBits(input int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frameBits(input int k);
    return 9 + parEn(k) + stopBits(k);
  endfunction

  // Frame as a list of line levels in transmit order; unused tail positions are idle-high.
  function automatic logic [11:0] buildFrame(input int k, input logic [7:0] d);
    logic [11:0] f;
    f = '1;
    f[0] = 1'b0;
    f[8:1] = d;
    if (parEn(k) != 0) f[9] = (^d) ^ (k == 2);
    return f;
  endfunction

  // Reference model: position inside the frame is elapsed cycles / CPB.
  logic [3:0]  exp_txd, exp_ready, exp_done;
  logic [11:0] frame [4];
  bit          busy [4];
  int          tcnt [4];

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!rstn) begin
        busy[k] = 1'b0;
        tcnt[k] = 0;
        exp_txd[k] = 1'b1;
        exp_ready[k] = 1'b1;
        exp_done[k] = 1'b0;
      end else if (!busy[k]) begin
        exp_done[k] = 1'b0;
        if (tx_start && exp_ready[k]) begin
          frame[k] = buildFrame(k, tx_data);
          busy[k] = 1'b1;
          tcnt[k] = 0;
          exp_txd[k] = frame[k][0];
          exp_ready[k] = 1'b0;
        end
      end else begin
        tcnt[k]++;
        if (tcnt[k] == frameBits(k) * CPB) begin
          busy[k] = 1'b0;
          exp_ready[k] = 1'b1;
          exp_done[k] = 1'b1;
          exp_txd[k] = 1'b1;
        end else begin
          exp_txd[k] = frame[k][tcnt[k] / CPB];
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    tests++;
    if (actual !== required) begin
      fails++;
      if (fails <= 40) $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("txd_cfg%0d t=%0t", k, $time), int'(act_txd[k]), int'(exp_txd[k]));
        checkOutput($sformatf("ready_cfg%0d t=%0t", k, $time), int'(act_ready[k]), int'(exp_ready[k]));
        checkOutput($sformatf("done_cfg%0d t=%0t", k, $time), int'(act_done[k]), int'(exp_done[k]));
      end
    end
  end

  logic [3:0] cap_txd   [0:199];
  logic [3:0] cap_ready [0:199];
  int         ready_low [4];
  int         done_cnt  [4];

  task automatic waitIdle();
    int i;
    i = 0;
    while (act_ready !== 4'hF && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (i >= 300) checkOutput("idle_timeout", 0, 1);
  endtask

  // Sends d; n=0 is the first negedge after the accepting edge, bit b sits at n=4b..4b+3.
  task automatic applyStimulus(input logic [7:0] d, input bit hold, input logic [7:0] d2,
                               input int poke_n, input int rst_n, input int cycles);
    waitIdle();
    @(negedge clk);
    tx_start = 1'b1;
    tx_data = d;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      ready_low[k] = 0;
      done_cnt[k] = 0;
    end
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      cap_txd[n] = act_txd;
      cap_ready[n] = act_ready;
      for (int k = 0; k < 4; k++) begin
        if (act_ready[k] == 1'b0) ready_low[k]++;
        if (act_done[k] == 1'b1) done_cnt[k]++;
      end
      if (n == 0) begin
        if (hold) tx_data = d2;
        else tx_start = 1'b0;
      end
      if (n == poke_n) begin
        tx_start = 1'b1;
        tx_data = 8'hFF;
      end
      if (n == poke_n + 1) tx_start = 1'b0;
      if (n == rst_n) rstn = 1'b0;
      if (n == rst_n + 1) rstn = 1'b1;
    end
    tx_start = 1'b0;
  endtask

  function automatic int sampledBits(input int k);
    int v;
    v = 0;
    for (int b = 0; b < 10; b++) v |= int'(cap_txd[4 * b + 2][k]) << b;
    return v;
  endfunction

  initial begin
    int run;
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_ready", int'(act_ready), 15);
    checkOutput("reset_txd", int'(act_txd), 15);
    checkOutput("reset_done", int'(act_done), 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] 0xA5 frame");
    applyStimulus(8'hA5, 1'b0, 8'h00, -10, -10, 50);
    checkOutput("a5_bits_8n1", sampledBits(0), 10'h34A);
    checkOutput("a5_ready_low_8n1", ready_low[0], 40);
    checkOutput("a5_ready_low_8e1", ready_low[1], 44);
    checkOutput("a5_ready_low_8n2", ready_low[3], 44);
    checkOutput("a5_done_pulses", done_cnt[0], 1);

    $display("[TB] 0x07 parity");
    applyStimulus(8'h07, 1'b0, 8'h00, -10, -10, 50);
    checkOutput("parity_even_bit", int'(cap_txd[38][1]), 1);
    checkOutput("parity_odd_bit", int'(cap_txd[38][2]), 0);
    checkOutput("parity_ready_low_even", ready_low[1], 44);
    checkOutput("parity_ready_low_odd", ready_low[2], 44);

    $display("[TB] back-to-back 0x55, 0xAA");
    applyStimulus(8'h55, 1'b1, 8'hAA, -10, -10, 90);
    run = 0;
    for (int n = 36; n < 60 && cap_txd[n][0] == 1'b1; n++) run++;
    checkOutput("b2b_bit7_low", int'(cap_txd[34][0]), 0);
    checkOutput("b2b_high_gap", run, 5);
    checkOutput("b2b_second_start", int'(cap_txd[41][0]), 0);
    checkOutput("b2b_second_bit1", int'(cap_txd[51][0]), 1);

    $display("[TB] start pulse while busy");
    applyStimulus(8'h00, 1'b0, 8'h00, 17, -10, 60);
    checkOutput("busy_bits", sampledBits(0), 10'h200);
    checkOutput("busy_ready_low", ready_low[0], 40);
    checkOutput("busy_done_pulses", done_cnt[0], 1);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hC3, 1'b0, 8'h00, -10, 13, 40);
    checkOutput("rst_txd_after", int'(cap_txd[14]), 15);
    checkOutput("rst_ready_after", int'(cap_ready[14]), 15);
    checkOutput("rst_no_done", done_cnt[0] + done_cnt[1] + done_cnt[2] + done_cnt[3], 0);
    applyStimulus(8'h3C, 1'b0, 8'h00, -10, -10, 50);
    checkOutput("post_rst_bits", sampledBits(0), 632);
    checkOutput("post_rst_ready_low", ready_low[0], 40);

    $display("[TB] two stop bits, 0x81");
    applyStimulus(8'h81, 1'b0, 8'h00, -10, -10, 50);
    run = 0;
    for (int n = 36; n < 44; n++) run += int'(cap_txd[n][3]);
    checkOutput("stop2_high_cycles", run, 8);
    checkOutput("stop2_ready_low", ready_low[3], 44);
    checkOutput("stop2_ready_back", int'(cap_ready[44][3]), 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      rstn = ($urandom_range(0, 399) != 0);
      tx_start = ($urandom_range(0, 3) == 0);
      tx_data = 8'($urandom);
    end
    @(negedge clk);
    rstn = 1'b1;
    tx_start = 1'b0;
    waitIdle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL expose the following parameters, one per line as name, default, meaning:
- CLKS_PER_BIT, 868, clk cycles per serial bit; legal range 2..65535.
- PARITY_EN, 0, 1 = append a parity bit after the data bits.
- PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

REQ-002 The block SHALL have exactly these ports, one per line as name, direction, width, meaning:
- clk  input  1  single clock; all logic on rising edge.
- rstn  input  1  reset; synchronous, active-low.
- tx_start_i  input  1  request to send tx_data_i.
- tx_data_i  input  8  byte to transmit.
- tx_ready_o  output  1  high only when idle and able to accept a byte.
- tx_done_o  output  1  one-cycle pulse at frame completion.
- txd_o  output  1  serial line; idles high.

REQ-003 There SHALL be one clock only, and reset SHALL be synchronous and active-low.

Function
REQ-004 The state machine SHALL have five states: IDLE, START, DATA, PARITY, STOP.

REQ-005 Acceptance rule: at a rising edge where tx_ready_o=1 and tx_start_i=1, the block SHALL:
- latch tx_data_i;
- enter START;
- drive tx_ready_o=0 and txd_o=0 from the next cycle.

REQ-006 tx_start_i SHALL be ignored whenever tx_ready_o=0.

REQ-007 Changes on tx_data_i after acceptance SHALL NOT affect the frame in progress.

REQ-008 Each serial bit SHALL be held on txd_o for exactly CLKS_PER_BIT cycles, timed by a baud counter that:
- is ceil(log2(CLKS_PER_BIT)) bits wide;
- counts 0..CLKS_PER_BIT-1;
- resets to 0 on every bit transition.

REQ-009 Bit order SHALL be:
- start bit (0);
- data bits 0..7, LSB first, tracked by a 3-bit index;
- parity bit, only if PARITY_EN=1;
- STOP_BITS stop bits (1).

REQ-010 The parity bit SHALL equal XOR of the 8 latched data bits when PARITY_ODD=0, and the inverse of that XOR when PARITY_ODD=1.

REQ-011 State transitions SHALL be:
- START -> DATA after one bit time.
- DATA -> PARITY, or -> STOP when PARITY_EN=0, after bit 7 completes.
- PARITY -> STOP after one bit time.
- STOP -> IDLE after STOP_BITS bit times.

REQ-012 On the STOP -> IDLE edge, tx_done_o SHALL pulse high for exactly one cycle, and tx_ready_o SHALL return to 1 in that same cycle.

REQ-013 Latency: from the accepting edge until tx_ready_o next reads 1, the block SHALL take exactly (9 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.

REQ-014 Back-to-back frames: if tx_start_i is held high, the next byte SHALL be accepted on the first edge with tx_ready_o=1, so txd_o stays high for exactly one extra cycle between frames.

REQ-015 In IDLE, txd_o SHALL be 1, tx_ready_o SHALL be 1, and tx_done_o SHALL be 0.

REQ-016 txd_o, tx_ready_o and tx_done_o SHALL be register outputs with no combinational path from any input.

Reset
REQ-017 At any rising edge with rstn=0, the block SHALL set state=IDLE, clear the baud counter and bit index, and drive txd_o=1, tx_ready_o=1 and tx_done_o=0 after that edge.

REQ-018 Reset asserted mid-frame SHALL abort the frame immediately, with no tx_done_o pulse.

REQ-019 While rstn=0, tx_start_i SHALL NOT be accepted.

REQ-020 The first frame after rstn returns high SHALL be fully correct.

Verification
REQ-021 The bench SHALL cover at least these directed scenarios, all with CLKS_PER_BIT=4 unless stated:
- 8N1, send 0xA5 -> txd_o = 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles; tx_ready_o low for 40 cycles; a single tx_done_o pulse.
- PARITY_EN=1: send 0x07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; tx_ready_o low for 44 cycles.
- tx_start_i held high with 0x55 and then 0xAA presented -> two correct frames, separated by exactly one idle-high cycle.
- Busy handling: pulse tx_start_i and change tx_data_i to 0xFF during data bit 3 of 0x00 -> frame unchanged (all-zero data) and no extra frame sent.
- Reset mid-frame: rstn low for 1 cycle during data bit 2 -> txd_o=1 and tx_ready_o=1 after that edge, no tx_done_o pulse; a subsequent send of 0x3C is correct.
- STOP_BITS=2, PARITY_EN=0: send 0x81 -> txd_o high for 8 cycles after bit 7; tx_ready_o low for 44 cycles.
